// File: rtl/id_if.sv
// Decode-stage handshake bundle: fetch-side request, flush, and decoded output.
// With ID_ILLEGAL_TRAP_EN defined the bundle also carries out_illegal.
interface id_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic [2:0]      out_immSel;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
`ifdef ID_ILLEGAL_TRAP_EN
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_immSel,
           out_rs1, out_rs2, out_rd, out_illegal
  );
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_immSel,
           out_rs1, out_rs2, out_rd, out_illegal
  );
`else
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_immSel,
           out_rs1, out_rs2, out_rd
  );
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_immSel,
           out_rs1, out_rs2, out_rd
  );
`endif
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: two-entry (main + skid) buffer that tags each entry
// with its immediate format. ID_ILLEGAL_TRAP_EN adds the out_illegal flag.
module id_stage #(
  parameter int PC_W = 32
) (
  input logic clk,
  input logic rst,
  id_if.slave bus
);

  // Handshake: a transfer happens on any edge where valid & ready are both 1;
  // valid never waits on ready, and in_ready is a pure flop output.
  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [2:0]      imm_sel;
`ifdef ID_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } entry_t;

  function automatic logic [2:0] decode_imm_sel(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd0;
      7'b0100011:                                     return 3'd1;
      7'b1100011:                                     return 3'd2;
      7'b1101111:                                     return 3'd3;
      7'b0110111, 7'b0010111:                         return 3'd4;
      7'b0110011:                                     return 3'd5;
      default:                                        return 3'd7;
    endcase
  endfunction

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_e;
  logic   in_fire;
  logic   out_fire;

  always_comb begin
    new_e         = '0;
    new_e.inst    = bus.in_inst;
    new_e.pc      = bus.in_pc;
    new_e.imm_sel = decode_imm_sel(bus.in_inst[6:0]);
`ifdef ID_ILLEGAL_TRAP_EN
    new_e.illegal = (new_e.imm_sel == 3'd7) || (bus.in_inst[1:0] != 2'b11);
`endif
  end

  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_fire = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (bus.flush) begin
      // Data is left untouched; only the valid bits are dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d = new_e;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q) begin
        main_d       = new_e;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = new_e;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready   = !skid_valid_q;
  assign bus.out_valid  = main_valid_q;
  assign bus.out_inst   = main_q.inst;
  assign bus.out_pc     = main_q.pc;
  assign bus.out_immSel = main_q.imm_sel;
  assign bus.out_rs1    = main_q.inst[19:15];
  assign bus.out_rs2    = main_q.inst[24:20];
  assign bus.out_rd     = main_q.inst[11:7];
`ifdef ID_ILLEGAL_TRAP_EN
  assign bus.out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios then random traffic,
// compared against an in-order queue model of the two-entry stage.
module tb_id_stage;
  localparam int PC_W = 32;
  localparam int W    = PC_W + 36;  // {illegal, imm_sel, pc, inst}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_if #(.PC_W(PC_W)) bus ();

  id_stage #(.PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [2:0] ref_sel(input logic [31:0] inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
      7'h23:                      return 3'd1;
      7'h63:                      return 3'd2;
      7'h6F:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h33:                      return 3'd5;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_entry(input logic [31:0] inst,
                                             input logic [PC_W-1:0] pc);
    logic [2:0] sel;
    logic       ill;
    sel = ref_sel(inst);
    ill = (sel == 3'd7) || (inst[1:0] != 2'b11);
    return {ill, sel, pc, inst};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, W'(bus.out_valid), '0);
    chk({tag, ".in_ready"}, W'(bus.in_ready), W'(1));
    chk({tag, ".out_inst"}, W'(bus.out_inst), '0);
    chk({tag, ".out_pc"}, W'(bus.out_pc), '0);
    chk({tag, ".out_immSel"}, W'(bus.out_immSel), '0);
    chk({tag, ".regs"}, W'({bus.out_rs1, bus.out_rs2, bus.out_rd}), '0);
`ifdef ID_ILLEGAL_TRAP_EN
    chk({tag, ".out_illegal"}, W'(bus.out_illegal), '0);
`endif
  endtask

  // Check current outputs against the model, then advance one clock.
  task automatic tick();
    int           occ;
    logic         in_fire;
    logic         out_fire;
    logic [W-1:0] e;
    occ = exp_q.size();
    chk("out_valid", W'(bus.out_valid), W'(occ > 0));
    chk("in_ready", W'(bus.in_ready), W'(occ < 2));
    if (occ > 0) begin
      e = exp_q[0];
      chk("out_inst", W'(bus.out_inst), W'(e[31:0]));
      chk("out_pc", W'(bus.out_pc), W'(e[PC_W+31:32]));
      chk("out_immSel", W'(bus.out_immSel), W'(e[PC_W+34:PC_W+32]));
      chk("out_rs1", W'(bus.out_rs1), W'(e[19:15]));
      chk("out_rs2", W'(bus.out_rs2), W'(e[24:20]));
      chk("out_rd", W'(bus.out_rd), W'(e[11:7]));
`ifdef ID_ILLEGAL_TRAP_EN
      chk("out_illegal", W'(bus.out_illegal), W'(e[PC_W+35]));
`endif
    end
    in_fire  = bus.in_valid && (occ < 2);
    out_fire = (occ > 0) && bus.out_ready;
    @(posedge clk);
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back(ref_entry(bus.in_inst, bus.in_pc));
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [PC_W-1:0] pc,
                       input logic fl, input logic ordy);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.flush     = fl;
    bus.out_ready = ordy;
    tick();
  endtask

  logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                            7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F, 7'h0B};
  logic [31:0] seq [4]  = '{32'h00112623, 32'h00208463, 32'h008000EF, 32'h123452B7};
  logic [31:0] r_inst;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // addi then idle
    drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b1);
    chk("addi.immSel", W'(bus.out_immSel), W'(0));
    chk("addi.rd", W'(bus.out_rd), W'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b1);

    // back-to-back S, B, J, U
    for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 32'(4 * i), 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);

    // stall: fill main and skid, third offer held off, then release
    drive(1'b1, 32'h00000033, 32'h100, 1'b0, 1'b0);
    drive(1'b1, 32'h0000007F, 32'h104, 1'b0, 1'b0);
    drive(1'b1, 32'h00A00113, 32'h108, 1'b0, 1'b0);
    drive(1'b1, 32'h00A00113, 32'h108, 1'b0, 1'b0);
    drive(1'b1, 32'h00A00113, 32'h108, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);

    // flush with both entries full and a new offer
    drive(1'b1, 32'h00000013, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 32'h00000017, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 32'hDEADB0B7, 32'h208, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);

    // reset mid-stall with skid full
    drive(1'b1, 32'h00000063, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h0000006F, 32'h304, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 32'h00000037, 32'h308, 1'b1, 1'b1);
    rst = 1'b0;
    chk_zero("rst_stall");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_inst = {$urandom()} & 32'hFFFF_FF80;
      r_inst[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) r_inst[1:0] = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), r_inst, 32'({$urandom()} & 32'hFFFF_FFFC),
            ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
